// File: rtl/seg7_pkg.sv
// Shared types and constants for the adder-result 7-segment display slice.
package seg7_pkg;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  localparam int unsigned BCD_W      = 12;
  localparam int unsigned ITER_COUNT = 9;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal codes blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_sum_display.sv
// Captures a 9-bit adder result, converts it to BCD by serial double-dabble and
// scans it onto a common-anode 3-digit display. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_sum_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t state_q, state_d;

  logic [8:0]       bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       iter_q;
  logic [BCD_W-1:0] bcd_shift;
  logic [8:0]       bin_shift;
  logic [3:0]       nib;
  logic             carry;
  logic             start;
  logic             done;

  logic [3:0] dig_units, dig_tens, dig_hund;

  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        idx_q;
  logic              scan_wrap;

  logic [3:0] sel_digit;
  logic [6:0] dec_seg;
  logic [6:0] seg_d;
  logic [2:0] an_d;

  assign busy = (state_q == CONVERT);

  // FSM next-state
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          start   = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (iter_q == 4'(ITER_COUNT - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Add-3 then shift; the bit leaving each nibble carries into the next one up.
  always_comb begin
    bcd_shift = '0;
    nib       = '0;
    carry     = bin_q[8];
    for (int unsigned i = 0; i < 3; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_shift[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
    bin_shift = {bin_q[7:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (start) begin
      bin_q  <= value;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (state_q == CONVERT) begin
      bin_q  <= bin_shift;
      bcd_q  <= bcd_shift;
      iter_q <= iter_q + 4'd1;
    end
  end

  // The final shift result goes straight to the display, so all digits flip together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_units <= '0;
      dig_tens  <= '0;
      dig_hund  <= '0;
    end else if (done) begin
      dig_units <= bcd_shift[3:0];
      dig_tens  <= bcd_shift[7:4];
      dig_hund  <= bcd_shift[11:8];
    end
  end

  assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
    end else if (scan_wrap) begin
      scan_q <= '0;
      idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  always_comb begin
    case (idx_q)
      2'd1:    sel_digit = dig_tens;
      2'd2:    sel_digit = dig_hund;
      default: sel_digit = dig_units;
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    case (idx_q)
      2'd1:    an_d = 3'b101;
      2'd2:    an_d = 3'b011;
      default: an_d = 3'b110;
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx_q == 2'd2 && dig_hund == 4'd0)
      seg_d = SEG_BLANK;
    if (idx_q == 2'd1 && dig_hund == 4'd0 && dig_tens == 4'd0)
      seg_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 3'b110;
      seg <= SEG_0;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_sum_display.sv
// Randomized self-checking bench for seg7_sum_display against a decimal-arithmetic model.
module tb_seg7_sum_display;

  localparam int unsigned SD = 4;

  logic       clk;
  logic       rst;
  logic [8:0] value;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [2:0] an;

  int tests;
  int failed;
  int shown;

  logic [6:0] seg_tab [10];

  seg7_sum_display #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .seg   (seg),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected segments for display position pos (0=units) when v is displayed.
  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int u, t, h;
    u = v % 10;
    t = (v / 10) % 10;
    h = v / 100;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (pos == 2 && h == 0) return 7'h7F;
    if (pos == 1 && h == 0 && t == 0) return 7'h7F;
`endif
    if (pos == 0) return seg_tab[u];
    if (pos == 1) return seg_tab[t];
    return seg_tab[h];
  endfunction

  task automatic check_disp(input string tag, input int v);
    int pos;
    pos = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : (an == 3'b011) ? 2 : -1;
    if (pos < 0) check({tag, "_an"}, 16'(an), 16'h0FFF);
    else         check(tag, 16'(seg), 16'(exp_seg(v, pos)));
  endtask

  task automatic scan_check(input int v);
    repeat (3 * SD + 1) begin
      @(negedge clk);
      check_disp("scan", v);
      check("idle_busy", 16'(busy), 16'd0);
    end
  endtask

  // Called at a negedge; load is seen at the next posedge (edge N).
  task automatic do_load(input int v, input int intrude, input int iv);
    value = 9'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("busy_n", 16'(busy), 16'd1);
    check_disp("hold", shown);
    for (int j = 1; j <= 9; j++) begin
      if (j == intrude) begin
        value = 9'(iv);
        load  = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      check(j < 9 ? "busy_hi" : "busy_lo", 16'(busy), (j < 9) ? 16'd1 : 16'd0);
      check_disp("hold", shown);
    end
    shown = v;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    tests  = 0;
    failed = 0;
    shown  = 0;
    rst    = 1'b1;
    load   = 1'b0;
    value  = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_an", 16'(an), 16'b110);
    check("rst_seg", 16'(seg), 16'b1000000);
    rst = 1'b0;

    // idle scan: index moves every SD edges, anodes follow one edge later
    for (int k = 1; k <= 20; k++) begin
      int ix;
      logic [2:0] ea;
      @(negedge clk);
      ix = ((k - 1) / SD) % 3;
      ea = (ix == 0) ? 3'b110 : (ix == 1) ? 3'b101 : 3'b011;
      check("idle_an", 16'(an), 16'(ea));
      check_disp("idle_seg", 0);
      check("idle_busy", 16'(busy), 16'd0);
    end

    do_load(255, 0, 0);
    scan_check(shown);
    do_load(511, 0, 0);
    scan_check(shown);
    do_load(0, 0, 0);
    scan_check(shown);
    do_load(37, 3, 100);
    scan_check(shown);
    do_load(7, 9, 300);
    do_load(105, 0, 0);
    scan_check(shown);

    // reset in the middle of a conversion
    value = 9'd300;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_an", 16'(an), 16'b110);
    check("abort_seg", 16'(seg), 16'b1000000);
    @(negedge clk);
    rst   = 1'b0;
    shown = 0;
    scan_check(shown);

    for (int r = 0; r < 30; r++) begin
      int v, iv, intr;
      v    = int'($urandom_range(0, 511));
      iv   = int'($urandom_range(0, 511));
      intr = int'($urandom_range(0, 9));
      do_load(v, intr, iv);
      if ($urandom_range(0, 1) == 1) scan_check(shown);
    end
    scan_check(shown);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_sum_display.md
# seg7_sum_display

Sequential display end of the adder datapath: captures a 9-bit adder result (8-bit sum plus carry-out, 0..511) on a load strobe. It converts the result to three BCD digits with a bit-serial double-dabble engine, then time-multiplexes the digits onto a common-anode 3-digit 7-segment display. It sits between the adder output and the board's segment/anode pins.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays lit; minimum 2.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- value  input  9  adder result {cout, sum[7:0]}; sampled only when load is accepted.
- load  input  1  single-cycle capture strobe; accepted only when busy=0.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  output  3  active-low one-hot anodes; an[0]=units, an[1]=tens, an[2]=hundreds.

## Operation
- FSM states are IDLE and CONVERT.
- IDLE with load=1:
  - copy value into the 9-bit shift register;
  - clear the 12-bit BCD scratch and the 4-bit iteration counter;
  - enter CONVERT; busy=1.
- CONVERT, each cycle:
  - each BCD nibble >=5 gets +3 added;
  - then {bcd,bin} shifts left by 1;
  - the iteration counter increments.
- After the 9th shift:
  - the result is written atomically into the three display digit registers;
  - FSM returns to IDLE; busy=0.
- load while busy is ignored. No queuing, and the pending conversion is unaffected.
- Scan counter:
  - free-runs 0..SCAN_DIV-1 and wraps to 0;
  - on each wrap, the 2-bit digit index advances 0->1->2->0; index 3 never occurs.
- an and seg are registered every cycle from the current index and display registers.
- Decoder, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10-15 give 1111111 (unreachable).
- Scanning runs continuously, including during conversion. The old digits stay displayed until the atomic update.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, display digits=0,0,0;
  - scan counter=0, index=0;
  - an=110, seg=1000000.
- Load accepted at edge N:
  - busy=1 from edge N through edge N+9, inclusive of the cycle before N+9's update;
  - display registers hold the new value after edge N+9; busy=0 after edge N+9;
  - seg reflects the new value after edge N+10.
- The earliest next accepted load is at edge N+10.
- an/seg change one cycle after the index changes. Each digit is lit for exactly SCAN_DIV cycles.
- Reset asserted mid-conversion aborts immediately. The display returns to 000 and the partial result is discarded.
- A load and the final shift cannot coincide in an accepted way: busy is still 1 at that edge.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - hundreds digit outputs seg=1111111 when it is 0;
  - tens digit outputs 1111111 when hundreds and tens are both 0;
  - units is never blanked;
  - anodes still scan normally.
  - After reset the display shows blank, blank, 0.
- Not defined: all three digits are always shown, including leading zeros.

## Structure
- seg7_pkg holds:
  - the FSM state enum;
  - the SEG_BLANK (7'h7F) constant;
  - the ten digit segment constants;
  - the BCD width constant (12) and the iteration count (9).
- Sub-module bcd_to_seg7: combinational 4-bit digit to active-low 7-bit segment decoder. It is instantiated once, fed by the index-selected digit.
- The top holds the FSM, double-dabble datapath, scan counter and output registers.

## Test plan
- Reset, then hold 20 cycles (SCAN_DIV=4) -> busy=0; an cycles 110,101,011 every 4 cycles; seg=1000000 throughout.
- load value=255 at edge N, SCAN_DIV=4 -> busy high 9 cycles; digits become units 5 (0010010), tens 5, hundreds 2 (0100100), each seen with the correct anode.
- load 511, then later load 0 -> display 1,1,5 then 0,0,0; busy drops exactly 9 cycles after each accepted load.
- load 37, then load 100 three cycles later -> second load ignored; display 7,3,0; busy pulse 9 cycles.
- load 300, assert rst at busy cycle 5 -> busy=0, an=110, seg=1000000 immediately; display stays 000 after release.
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - load 7 -> hundreds and tens 1111111, units 1111000;
  - load 105 -> tens shows 1000000, hundreds 1111001.
